pc_fetch: RTL and testbench

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction ROM. It drives the ROM's A-bit `instr_address` and advances it each cycle in sequence, or to a jump/branch target. Run control is a start/done handshake with halt and stall. It also reports a saturating count of retired fetches for the test harness.

---
 rtl/pc_fetch.sv | 105 ++++++++++
 tb/tb_pc_fetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Brief    : Program counter / fetch sequencer in front of the instruction ROM,
//            with start/done run control, stall, jumps and a retired-fetch count.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter int A  = 10,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          jump_en,
    input  logic          jump_abs,
    input  logic [A-1:0]  jump_target,
    output logic [A-1:0]  instr_address,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [A-1:0]  c_pc_one    = {{(A-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_count_one = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_count_max = {CW{1'b1}};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [A-1:0]  r_pc;
    logic [A-1:0]  w_pc_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_fetch_valid;
    logic          r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_count       <= '0;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_count       <= w_count_nxt;
            // Flags are registered from the next state so they line up with the PC.
            r_fetch_valid <= (w_state_nxt == ST_RUN);
            r_done        <= (w_state_nxt == ST_HALTED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_count_nxt = '0;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_nxt = ST_HALTED;
                end else if (!stall) begin
                    // Relative offsets are two's complement, so a plain A-bit add wraps correctly.
                    if (jump_en && jump_abs) begin
                        w_pc_nxt = jump_target;
                    end else if (jump_en) begin
                        w_pc_nxt = r_pc + jump_target;
                    end else begin
                        w_pc_nxt = r_pc + c_pc_one;
                    end
                    if (r_count != c_count_max) begin
                        w_count_nxt = r_count + c_count_one;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    assign instr_address = r_pc;
    assign fetch_valid   = r_fetch_valid;
    assign done          = r_done;
    assign instr_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch
// Brief    : Directed + random bench for pc_fetch against a run-level model;
//            a second instance with a 4-bit counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    localparam int A      = 10;
    localparam int CW     = 16;
    localparam int CW_SAT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          halt_req = 1'b0;
    logic          jump_en = 1'b0;
    logic          jump_abs = 1'b0;
    logic [A-1:0]  jump_target = '0;

    logic [A-1:0]      instr_address;
    logic              fetch_valid;
    logic              done;
    logic [CW-1:0]     instr_count;
    logic [A-1:0]      sat_address;
    logic              sat_fetch_valid;
    logic              sat_done;
    logic [CW_SAT-1:0] sat_count;

    pc_fetch #(.A(A), .CW(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .halt_req(halt_req), .jump_en(jump_en), .jump_abs(jump_abs),
        .jump_target(jump_target), .instr_address(instr_address),
        .fetch_valid(fetch_valid), .done(done), .instr_count(instr_count)
    );

    pc_fetch #(.A(A), .CW(CW_SAT)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .halt_req(halt_req), .jump_en(jump_en), .jump_abs(jump_abs),
        .jump_target(jump_target), .instr_address(sat_address),
        .fetch_valid(sat_fetch_valid), .done(sat_done), .instr_count(sat_count)
    );

    always #5 clk = ~clk;

    // Reference model: run mode 0=idle 1=run 2=halted, unbounded PC/advance count.
    int m_mode = 0;
    int m_pc   = 0;
    int m_adv  = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_edge(input logic s, st, h, je, ja, input logic [A-1:0] t);
        int off;
        if (m_mode == 1) begin
            if (h) m_mode = 2;
            else if (!st) begin
                if (je && ja) m_pc = int'(t);
                else if (je) begin
                    off  = (int'(t) >= (1 << (A-1))) ? int'(t) - (1 << A) : int'(t);
                    m_pc = ((m_pc + off) % (1 << A) + (1 << A)) % (1 << A);
                end else m_pc = (m_pc + 1) % (1 << A);
                m_adv++;
            end
        end else if (s) begin
            m_mode = 1;
            m_pc   = 0;
            m_adv  = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int max16, max4;
        max16 = (1 << CW) - 1;
        max4  = (1 << CW_SAT) - 1;
        chk("instr_address", 32'(instr_address), 32'(m_pc));
        chk("fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("instr_count", 32'(instr_count), 32'((m_adv > max16) ? max16 : m_adv));
        chk("sat_count", 32'(sat_count), 32'((m_adv > max4) ? max4 : m_adv));
        chk("sat_address", 32'(sat_address), 32'(m_pc));
    endtask

    task automatic step(input logic s, st, h, je, ja, input logic [A-1:0] t);
        @(negedge clk);
        start = s; stall = st; halt_req = h; jump_en = je; jump_abs = ja; jump_target = t;
        @(posedge clk);
        model_edge(s, st, h, je, ja, t);
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;

        // Start pulse then five plain fetches
        step(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, '0);

        // Absolute to 3, absolute to 0x200, relative -2
        step(0, 0, 0, 1, 1, 10'h003);
        step(0, 0, 0, 1, 1, 10'h200);
        step(0, 0, 0, 1, 0, 10'h3FE);

        // Wrap at top of address space, self-loop, stall with jump pending
        step(0, 0, 0, 1, 1, 10'h3FE);
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);
        step(0, 0, 0, 1, 0, 10'h000);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 10'h123);

        // Halt at 7, hold while halted, restart, start ignored in RUN
        step(0, 0, 0, 1, 1, 10'h007);
        step(0, 0, 1, 1, 1, 10'h0AA);
        step(0, 1, 1, 1, 0, 10'h011);
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);

        // Long plain run pushes the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, '0);

        // Random control mix
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), A'($urandom));
        end

        // Reach 0x155 and stall, then assert reset mid-cycle
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 0, 1, 1, 10'h155);
        step(0, 1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        #2 rst_n = 1'b0;
        m_mode = 0; m_pc = 0; m_adv = 0;
        #1 check_all();
        @(negedge clk) rst_n = 1'b1;
        stall = 1'b0;
        step(0, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        step(0, 0, 0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
